// File: rtl/in_port.sv
// Switch-capture input port: a debounced enter button latches the synchronized
// switch word into a small FIFO that a consumer drains one word per read.
module in_port #(
  parameter int DEB_CYCLES = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [15:0]                sw,
  input  logic                       btn,
  input  logic                       rd_en,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic          btn_p0, btn_p1;
  logic [15:0]   sw_p0, sw_p1;
  logic [DW-1:0] deb_cnt;
  logic          level, level_d;
  logic          capture, pop, push, drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [DEPTH];

  // Stage p0/p1: two-flop synchronizers for the asynchronous button and switches
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
    end
  end

  // Debounce: level flips only after DEB_CYCLES consecutive mismatching samples
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_cnt <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (btn_p1 == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        level   <= ~level;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Press edge only; a pop frees a slot so a capture into a full FIFO still lands
  assign capture = level & ~level_d;
  assign pop     = rd_en & ~empty;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  always_ff @(posedge clock) begin
    if (push && !reset) mem[wr_ptr] <= sw_p1;
  end

  // FIFO control and registered read port
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_in_port.sv
// Bench for in_port: a queue-based reference model checked every cycle,
// plus directed press/read scenarios with literal expectations.
module tb_in_port;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sw    = '0;
  logic        btn   = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, overflow;
  logic [2:0]  count;

  in_port #(.DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sw(sw), .btn(btn), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, button level as "last DEB samples all differ"
  bit          model_ok = 0;
  bit          m_b0, m_b1;
  logic [15:0] m_sw0, m_sw1;
  bit          hist [DEB];
  bit          m_level, m_level_d;
  logic [15:0] q [$];
  logic [15:0] m_rd_data;
  bit          m_rd_valid, m_ovf;

  always @(posedge clock) begin
    bit          cap, popm, all_mis;
    int          sz;
    logic [15:0] swv;
    if (reset) begin
      m_b0 = 0; m_b1 = 0; m_sw0 = '0; m_sw1 = '0;
      foreach (hist[i]) hist[i] = 0;
      m_level = 0; m_level_d = 0;
      q.delete();
      m_rd_data = '0; m_rd_valid = 0; m_ovf = 0;
      model_ok = 1;
    end else if (model_ok) begin
      swv  = m_sw1;
      cap  = m_level && !m_level_d;
      sz   = q.size();
      popm = rd_en && (sz > 0);
      m_rd_valid = popm;
      if (popm) m_rd_data = q.pop_front();
      if (cap) begin
        if (sz < DEPTH || popm) q.push_back(swv);
        else m_ovf = 1;
      end
      m_level_d = m_level;
      for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_b1;
      all_mis = 1;
      foreach (hist[i]) if (hist[i] == m_level) all_mis = 0;
      if (all_mis) m_level = !m_level;
      m_b1 = m_b0; m_b0 = btn;
      m_sw1 = m_sw0; m_sw0 = sw;
    end
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("model rd_data", rd_data, m_rd_data);
      check("model rd_valid", rd_valid, m_rd_valid);
      check("model count", count, q.size());
      check("model empty", empty, q.size() == 0);
      check("model full", full, q.size() == DEPTH);
      check("model overflow", overflow, m_ovf);
    end
  end

  // btn rises before edge 1; returns just before edge DEB+3 (the capture edge)
  task automatic press_start(input logic [15:0] v);
    @(negedge clock);
    sw  = v;
    btn = 1'b1;
    repeat (DEB + 2) @(negedge clock);
  endtask

  task automatic press_capture();
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic press_release();
    repeat (6) @(negedge clock);
    btn = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic press(input logic [15:0] v);
    press_start(v);
    press_capture();
    press_release();
  endtask

  task automatic read_expect(input string name, input logic [15:0] v);
    @(negedge clock);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    check(name, rd_data, v);
    check({name, " valid"}, rd_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset count", count, 3'd0);
    check("reset empty", empty, 1'b1);
    check("reset full", full, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset rd_data", rd_data, 16'h0000);
    check("reset rd_valid", rd_valid, 1'b0);

    // Single press: capture lands on edge DEB+3
    press_start(16'h1234);
    check("pre-capture count", count, 3'd0);
    press_capture();
    check("capture count", count, 3'd1);
    repeat (12) @(negedge clock);
    btn = 1'b0;
    repeat (8) @(negedge clock);
    read_expect("read 1234", 16'h1234);
    check("read 1234 empty", empty, 1'b1);

    // Bounces shorter than DEB cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); btn = ~i[0];
      @(negedge clock);
    end
    btn = 1'b0;
    repeat (10) @(negedge clock);
    check("bounce count", count, 3'd0);
    check("bounce overflow", overflow, 1'b0);

    // Five presses into a four-deep FIFO
    for (int i = 1; i <= 5; i++) press(16'(i));
    check("fill count", count, 3'd4);
    check("fill full", full, 1'b1);
    check("fill overflow", overflow, 1'b1);
    read_expect("fifo read 1", 16'd1);
    read_expect("fifo read 2", 16'd2);
    read_expect("fifo read 3", 16'd3);
    read_expect("fifo read 4", 16'd4);
    check("drained empty", empty, 1'b1);

    // Full FIFO: capture and pop in the same cycle
    press(16'h00A0); press(16'h00B0); press(16'h00C0); press(16'h00D0);
    press_start(16'h00E0);
    rd_en = 1'b1;
    press_capture();
    check("full swap count", count, 3'd4);
    check("full swap data", rd_data, 16'h00A0);
    check("full swap valid", rd_valid, 1'b1);
    check("full swap overflow", overflow, 1'b1);
    press_release();
    read_expect("swap read B", 16'h00B0);
    read_expect("swap read C", 16'h00C0);
    read_expect("swap read D", 16'h00D0);
    read_expect("swap read E", 16'h00E0);

    // Read while empty coinciding with a capture: no fall-through
    press_start(16'hBEEF);
    rd_en = 1'b1;
    press_capture();
    check("empty rd valid", rd_valid, 1'b0);
    check("empty rd data", rd_data, 16'h00E0);
    check("empty rd count", count, 3'd1);
    press_release();
    read_expect("read BEEF", 16'hBEEF);

    // Reset mid-operation with the button held through it
    press(16'h0011);
    press(16'h0022);
    check("pre-reset count", count, 3'd2);
    @(negedge clock);
    reset = 1'b1;
    btn   = 1'b1;
    sw    = 16'h0033;
    @(negedge clock);
    reset = 1'b0;
    check("mid reset count", count, 3'd0);
    check("mid reset empty", empty, 1'b1);
    check("mid reset rd_data", rd_data, 16'h0000);
    check("mid reset overflow", overflow, 1'b0);
    repeat (DEB + 2) @(negedge clock);
    check("post-reset edge6 count", count, 3'd0);
    @(negedge clock);
    check("post-reset edge7 count", count, 3'd1);
    repeat (6) @(negedge clock);
    btn = 1'b0;
    repeat (8) @(negedge clock);
    read_expect("post-reset read", 16'h0033);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
